// File: rtl/ldpc_block_store.sv
// Message/parity block store for the LDPC stored/new selection stage: loads message blocks,
// captures encoder write-backs by index, then drains every slot in order.
package LDPC_pkg;
  localparam int unsigned MAX_ZC = 384;
endpackage

module ldpc_block_store
  import LDPC_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = 23,
  parameter int unsigned IDX_W      = $clog2(NUM_BLOCKS),
  parameter int unsigned CNT_W      = $clog2(NUM_BLOCKS + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 start_i,
  input  logic [CNT_W-1:0]                     num_msg_cfg_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [MAX_ZC-1:0]                    in_block_i,
  output logic                                 msg_ready_o,
  input  logic                                 wb_valid_i,
  input  logic [IDX_W-1:0]                     wb_idx_i,
  input  logic [MAX_ZC-1:0]                    wb_block_i,
  input  logic                                 enc_done_i,
  output logic [NUM_BLOCKS-1:0][MAX_ZC-1:0]    stored_msg_blocks_o,
  output logic [NUM_BLOCKS-1:0][MAX_ZC-1:0]    new_msg_parity_blocks_o,
  output logic [NUM_BLOCKS-1:0]                select_lines_o,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [MAX_ZC-1:0]                    out_block_o,
  output logic                                 out_last_o,
  output logic                                 frame_done_o
);

  localparam logic [IDX_W-1:0] LastIdx   = IDX_W'(NUM_BLOCKS - 1);
  localparam logic [CNT_W-1:0] NumBlkCnt = CNT_W'(NUM_BLOCKS);

  typedef enum logic [1:0] {StIdle, StLoad, StEncode, StUnload} state_e;

  state_e                            state_q, state_d;
  logic [NUM_BLOCKS-1:0][MAX_ZC-1:0] stored_q, stored_d;
  logic [NUM_BLOCKS-1:0][MAX_ZC-1:0] new_q, new_d;
  logic [NUM_BLOCKS-1:0]             sel_q, sel_d;
  logic [CNT_W-1:0]                  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]                  n_q, n_d;
  logic [IDX_W-1:0]                  rd_cnt_q, rd_cnt_d;
  logic                              frame_done_q, frame_done_d;
  logic [CNT_W-1:0]                  wr_cnt_inc;
  logic                              rd_last;

  assign wr_cnt_inc = wr_cnt_q + CNT_W'(1);
  assign rd_last    = (rd_cnt_q == LastIdx);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_i) state_d = StLoad;
      StLoad:   if (in_valid_i && (wr_cnt_inc == n_q)) state_d = StEncode;
      StEncode: if (enc_done_i) state_d = StUnload;
      StUnload: if (out_ready_i && rd_last) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    stored_d     = stored_q;
    new_d        = new_q;
    sel_d        = sel_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    n_d          = n_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          // Out-of-range or zero counts fall back to a full load.
          n_d      = ((num_msg_cfg_i == '0) || (num_msg_cfg_i > NumBlkCnt)) ? NumBlkCnt
                                                                             : num_msg_cfg_i;
          stored_d = '0;
          new_d    = '0;
          sel_d    = '0;
          wr_cnt_d = '0;
        end
      end
      StLoad: begin
        if (in_valid_i) begin
          stored_d[wr_cnt_q[IDX_W-1:0]] = in_block_i;
          wr_cnt_d                      = wr_cnt_inc;
        end
      end
      StEncode: begin
        if (wb_valid_i && (wb_idx_i <= LastIdx)) begin
          new_d[wb_idx_i] = wb_block_i;
          sel_d[wb_idx_i] = 1'b1;
        end
        if (enc_done_i) rd_cnt_d = '0;
      end
      StUnload: begin
        if (out_ready_i) begin
          rd_cnt_d     = rd_cnt_q + IDX_W'(1);
          frame_done_d = rd_last;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stored_q     <= '0;
      new_q        <= '0;
      sel_q        <= '0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      n_q          <= '0;
      frame_done_q <= 1'b0;
    end else begin
      stored_q     <= stored_d;
      new_q        <= new_d;
      sel_q        <= sel_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      n_q          <= n_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    in_ready_o              = (state_q == StLoad);
    msg_ready_o             = (state_q == StEncode);
    out_valid_o             = (state_q == StUnload);
    out_last_o              = (state_q == StUnload) && rd_last;
    out_block_o             = '0;
    if (state_q == StUnload) begin
      out_block_o = sel_q[rd_cnt_q] ? new_q[rd_cnt_q] : stored_q[rd_cnt_q];
    end
    stored_msg_blocks_o     = stored_q;
    new_msg_parity_blocks_o = new_q;
    select_lines_o          = sel_q;
    frame_done_o            = frame_done_q;
  end

endmodule

// File: tb/tb_ldpc_block_store.sv
// Bench for ldpc_block_store: frame-level reference model checked every cycle, plus
// literal checks on the drained beat log.
module tb_ldpc_block_store;
  import LDPC_pkg::*;

  localparam int NB    = 23;
  localparam int IDX_W = 5;
  localparam int CNT_W = 5;

  typedef logic [MAX_ZC-1:0] blk_t;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b0;
  logic                         start = 1'b0;
  logic [CNT_W-1:0]             cfg = '0;
  logic                         in_valid = 1'b0;
  blk_t                         in_block = '0;
  logic                         wb_valid = 1'b0;
  logic [IDX_W-1:0]             wb_idx = '0;
  blk_t                         wb_block = '0;
  logic                         enc_done = 1'b0;
  logic                         out_ready = 1'b0;

  logic                         in_ready_o, msg_ready_o, out_valid_o, out_last_o, frame_done_o;
  logic [NB-1:0][MAX_ZC-1:0]    stored_o, new_o;
  logic [NB-1:0]                sel_o;
  blk_t                         out_block_o;

  ldpc_block_store #(.NUM_BLOCKS(NB)) dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .start_i                (start),
    .num_msg_cfg_i          (cfg),
    .in_valid_i             (in_valid),
    .in_ready_o             (in_ready_o),
    .in_block_i             (in_block),
    .msg_ready_o            (msg_ready_o),
    .wb_valid_i             (wb_valid),
    .wb_idx_i               (wb_idx),
    .wb_block_i             (wb_block),
    .enc_done_i             (enc_done),
    .stored_msg_blocks_o    (stored_o),
    .new_msg_parity_blocks_o(new_o),
    .select_lines_o         (sel_o),
    .out_valid_o            (out_valid_o),
    .out_ready_i            (out_ready),
    .out_block_o            (out_block_o),
    .out_last_o             (out_last_o),
    .frame_done_o           (frame_done_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input blk_t act, input blk_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: phase 0 idle, 1 loading, 2 awaiting write-backs, 3 draining.
  int   m_phase, m_n, m_wr, m_rd;
  blk_t m_stored[NB];
  blk_t m_new[NB];
  bit   m_sel[NB];
  bit   m_fd;

  blk_t drain_q[$];
  bit   last_q[$];
  int   fd_cnt = 0;

  task automatic model_clear_banks();
    for (int i = 0; i < NB; i++) begin
      m_stored[i] = '0;
      m_new[i]    = '0;
      m_sel[i]    = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_n     = 0;
    m_wr    = 0;
    m_rd    = 0;
    m_fd    = 1'b0;
    model_clear_banks();
  endtask

  task automatic model_step();
    m_fd = 1'b0;
    case (m_phase)
      0: if (start) begin
        m_n = (cfg == 0 || int'(cfg) > NB) ? NB : int'(cfg);
        model_clear_banks();
        m_wr    = 0;
        m_phase = 1;
      end
      1: if (in_valid) begin
        m_stored[m_wr] = in_block;
        m_wr++;
        if (m_wr == m_n) m_phase = 2;
      end
      2: begin
        if (wb_valid && int'(wb_idx) < NB) begin
          m_new[wb_idx] = wb_block;
          m_sel[wb_idx] = 1'b1;
        end
        if (enc_done) begin
          m_phase = 3;
          m_rd    = 0;
        end
      end
      default: if (out_ready) begin
        if (m_rd == NB - 1) begin
          m_phase = 0;
          m_fd    = 1'b1;
        end else begin
          m_rd++;
        end
      end
    endcase
  endtask

  task automatic compare();
    logic [NB-1:0] exp_sel;
    blk_t          exp_blk;
    for (int i = 0; i < NB; i++) exp_sel[i] = m_sel[i];
    exp_blk = '0;
    if (m_phase == 3) exp_blk = m_sel[m_rd] ? m_new[m_rd] : m_stored[m_rd];
    chk("in_ready", in_ready_o, m_phase == 1);
    chk("msg_ready", msg_ready_o, m_phase == 2);
    chk("out_valid", out_valid_o, m_phase == 3);
    chk("out_last", out_last_o, (m_phase == 3) && (m_rd == NB - 1));
    chk("out_block", out_block_o, exp_blk);
    chk("frame_done", frame_done_o, m_fd);
    chk("select_lines", sel_o, exp_sel);
    for (int i = 0; i < NB; i++) begin
      chk($sformatf("stored[%0d]", i), stored_o[i], m_stored[i]);
      chk($sformatf("new[%0d]", i), new_o[i], m_new[i]);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      compare();
      if (rst_n) begin
        if (out_valid_o && out_ready) begin
          drain_q.push_back(out_block_o);
          last_q.push_back(out_last_o);
        end
        if (frame_done_o) fd_cnt++;
        model_step();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int c);
    cfg   = CNT_W'(c);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load(input int k, input int base);
    for (int i = 0; i < k; i++) begin
      in_valid = 1'b1;
      in_block = blk_t'(base + i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wb(input int idx, input int val, input bit done);
    wb_valid = 1'b1;
    wb_idx   = IDX_W'(idx);
    wb_block = blk_t'(val);
    enc_done = done;
    tick();
    wb_valid = 1'b0;
    enc_done = 1'b0;
  endtask

  task automatic done_pulse();
    enc_done = 1'b1;
    tick();
    enc_done = 1'b0;
  endtask

  // Drains until frame_done; bp selects the 1,0,0,1 ready pattern, start_at pokes start.
  task automatic drain(input bit bp, input int start_at, input bit b2b);
    bit got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      if (frame_done_o) begin
        got       = 1'b1;
        out_ready = 1'b0;
        cfg       = CNT_W'(1);
        start     = b2b;
        tick();
        start = 1'b0;
      end else begin
        out_ready = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
        start     = (c == start_at);
        tick();
        start = 1'b0;
      end
    end
    out_ready = 1'b0;
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got no frame_done expected pulse within 200 cycles");
    end
  endtask

  task automatic new_frame_log();
    drain_q.delete();
    last_q.delete();
    fd_cnt = 0;
  endtask

  initial begin
    tick();
    tick();
    chk("reset out_valid", out_valid_o, 0);
    chk("reset frame_done", frame_done_o, 0);
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a load.
    start_frame(10);
    load(7, 1);
    chk("pre-reset stored[6]", stored_o[6], 7);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("mid-reset in_ready", in_ready_o, 0);
    chk("mid-reset stored[6]", stored_o[6], 0);
    chk("mid-reset select", sel_o, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Full frame of 22 without write-back.
    new_frame_log();
    start_frame(22);
    chk("t2 in_ready after start", in_ready_o, 1);
    load(22, 1);
    chk("t2 msg_ready", msg_ready_o, 1);
    chk("t2 in_ready after load", in_ready_o, 0);
    done_pulse();
    drain(1'b0, -1, 1'b0);
    chk("t2 beat count", drain_q.size(), 23);
    for (int i = 0; i < drain_q.size() && i < 23; i++) begin
      chk($sformatf("t2 beat %0d", i), drain_q[i], (i < 22) ? i + 1 : 0);
      chk($sformatf("t2 last %0d", i), last_q[i], i == 22);
    end
    chk("t2 frame_done count", fd_cnt, 1);

    // Write-backs to slots 3 and 22.
    new_frame_log();
    start_frame(22);
    load(22, 1);
    wb(3, 'hAAA, 1'b0);
    wb(22, 'hBBB, 1'b0);
    chk("t3 select_lines", sel_o, 23'h400008);
    done_pulse();
    drain(1'b0, -1, 1'b0);
    chk("t3 beat count", drain_q.size(), 23);
    if (drain_q.size() == 23) begin
      chk("t3 beat 3", drain_q[3], 'hAAA);
      chk("t3 beat 22", drain_q[22], 'hBBB);
      chk("t3 beat 0", drain_q[0], 1);
      chk("t3 beat 21", drain_q[21], 22);
    end

    // cfg 0 loads all 23, ignored inputs, write-back corner cases, backpressure.
    new_frame_log();
    start_frame(0);
    load(22, 1);
    chk("t4 in_ready after 22", in_ready_o, 1);
    load(1, 23);
    in_valid = 1'b1;
    in_block = blk_t'('hDEAD);
    wb(25, 'h55, 1'b0);
    in_valid = 1'b0;
    wb(5, 'h11, 1'b0);
    wb(5, 'h22, 1'b0);
    wb(0, 'h33, 1'b1);
    chk("t4 select_lines", sel_o, 23'h21);
    chk("t4 stored[22]", stored_o[22], 23);
    drain(1'b1, 4, 1'b0);
    chk("t4 beat count", drain_q.size(), 23);
    if (drain_q.size() == 23) begin
      chk("t4 beat 0", drain_q[0], 'h33);
      chk("t4 beat 1", drain_q[1], 2);
      chk("t4 beat 5", drain_q[5], 'h22);
      chk("t4 beat 22", drain_q[22], 23);
    end
    chk("t4 frame_done count", fd_cnt, 1);

    // Back-to-back: start in the frame_done cycle, then a 1-block frame.
    new_frame_log();
    start_frame(3);
    load(3, 'h100);
    done_pulse();
    drain(1'b0, -1, 1'b1);
    chk("t5 b2b in_ready", in_ready_o, 1);
    load(1, 'h77);
    done_pulse();
    drain_q.delete();
    last_q.delete();
    drain(1'b0, -1, 1'b0);
    chk("t5 beat count", drain_q.size(), 23);
    if (drain_q.size() == 23) begin
      chk("t5 beat 0", drain_q[0], 'h77);
      chk("t5 beat 1", drain_q[1], 0);
    end

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
